// File: rtl/pll_drp_config.sv
// ---------------------------------------------------------------------------
// pll_drp_config
//
// DRP register file and decoder for the PLL simulation model. Holds the
// output-counter, feedback and input-divider registers written over a
// 7-series-style DRP port. It decodes them into the integer divide,
// duty-cycle (x1000) and phase values that the PLL core uses to override its
// static parameters. A decoded value of 0 means "not configured, keep the
// static parameter".
//
// Ports
//   DCLK                         sole clock, rising edge
//   RST                          asynchronous reset, active low
//   PWRDWN                       blocks DRP accesses and zeroes decoded outputs
//   DADDR/DEN/DWE/DI             DRP request (one-cycle DEN strobe)
//   DO/DRDY                      DRP response, DRDY one cycle after DEN
//   CLKOUTn_DIVIDE               decoded divide, n = 0..6
//   CLKOUTn_DUTY_CYCLE_1000      decoded duty cycle x1000, n = 0..6
//   CLKOUTn_PHASE                decoded phase in degrees, n = 0..6
//   CLKFBOUT_MULT_F_1000         feedback multiplier x1000
//   CLKFBOUT_PHASE               feedback phase in degrees
//   DIVCLK_DIVIDE                input divider
// ---------------------------------------------------------------------------
module pll_drp_config (
  input  logic        DCLK,
  input  logic        RST,
  input  logic        PWRDWN,
  input  logic [6:0]  DADDR,
  input  logic        DEN,
  input  logic        DWE,
  input  logic [15:0] DI,
  output logic [15:0] DO,
  output logic        DRDY,
  output logic [31:0] CLKOUT0_DIVIDE,
  output logic [31:0] CLKOUT0_DUTY_CYCLE_1000,
  output logic [31:0] CLKOUT0_PHASE,
  output logic [31:0] CLKOUT1_DIVIDE,
  output logic [31:0] CLKOUT1_DUTY_CYCLE_1000,
  output logic [31:0] CLKOUT1_PHASE,
  output logic [31:0] CLKOUT2_DIVIDE,
  output logic [31:0] CLKOUT2_DUTY_CYCLE_1000,
  output logic [31:0] CLKOUT2_PHASE,
  output logic [31:0] CLKOUT3_DIVIDE,
  output logic [31:0] CLKOUT3_DUTY_CYCLE_1000,
  output logic [31:0] CLKOUT3_PHASE,
  output logic [31:0] CLKOUT4_DIVIDE,
  output logic [31:0] CLKOUT4_DUTY_CYCLE_1000,
  output logic [31:0] CLKOUT4_PHASE,
  output logic [31:0] CLKOUT5_DIVIDE,
  output logic [31:0] CLKOUT5_DUTY_CYCLE_1000,
  output logic [31:0] CLKOUT5_PHASE,
  output logic [31:0] CLKOUT6_DIVIDE,
  output logic [31:0] CLKOUT6_DUTY_CYCLE_1000,
  output logic [31:0] CLKOUT6_PHASE,
  output logic [31:0] CLKFBOUT_MULT_F_1000,
  output logic [31:0] CLKFBOUT_PHASE,
  output logic [31:0] DIVCLK_DIVIDE
);

  // Counter slots in address order: pair k lives at 0x06+2k / 0x07+2k.
  // Slot 0 = CLKOUT5, 1..5 = CLKOUT0..4, 6 = CLKOUT6, 7 = CLKFBOUT.
  localparam int N_CNT   = 8;
  localparam int N_MISC  = 6;

  typedef struct packed {
    logic [31:0] divide;
    logic [31:0] duty;
    logic [31:0] phase;
  } dec_t;

  // A HIGH/LOW field of 0 encodes 64.
  function automatic logic [31:0] field_val(input logic [5:0] f);
    return (f == 6'd0) ? 32'd64 : {26'd0, f};
  endfunction

  function automatic logic [31:0] divide_of(input logic       nc,
                                            input logic [5:0] high_f,
                                            input logic [5:0] low_f);
    return nc ? 32'd1 : field_val(high_f) + field_val(low_f);
  endfunction

  function automatic dec_t decode(input logic       en,
                                  input logic [2:0] mux,
                                  input logic [5:0] high_f,
                                  input logic [5:0] low_f,
                                  input logic       edge_b,
                                  input logic       nc,
                                  input logic [5:0] delay);
    dec_t        r;
    logic [31:0] d;
    d        = divide_of(nc, high_f, low_f);
    r.divide = d;
    r.duty   = nc ? 32'd500
                  : ((32'd2 * field_val(high_f) + {31'd0, edge_b}) * 32'd500) / d;
    r.phase  = (({26'd0, delay} * 32'd8 + {29'd0, mux}) * 32'd45) / d;
    if (!en) r = '0;
    return r;
  endfunction

  // Storage
  logic [15:0]      reg1 [N_CNT];
  logic [15:0]      reg2 [N_CNT];
  logic [15:0]      divclk_reg;
  logic [15:0]      misc_reg [N_MISC];
  logic [N_CNT-1:0] cnt_cfg;
  logic             div_cfg;

  // Address decode
  logic [6:0]  addr_off;
  logic        cnt_hit;
  logic [2:0]  cnt_idx;
  logic        cnt_sel2;
  logic        div_hit;
  logic        misc_hit;
  logic [2:0]  misc_idx;
  logic [15:0] rdata;
  logic        access;
  logic        wr_en;

  assign access = DEN && !PWRDWN;
  assign wr_en  = access && DWE;

  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    addr_off = DADDR - 7'h06;
    cnt_hit  = (DADDR >= 7'h06) && (DADDR <= 7'h15);
    cnt_idx  = addr_off[3:1];
    cnt_sel2 = DADDR[0];                 // odd address = Reg2 of the pair
    div_hit  = (DADDR == 7'h16);
    misc_hit = 1'b1;
    misc_idx = 3'd0;
    case (DADDR)
      7'h18:   misc_idx = 3'd0;
      7'h19:   misc_idx = 3'd1;
      7'h1A:   misc_idx = 3'd2;
      7'h28:   misc_idx = 3'd3;
      7'h4E:   misc_idx = 3'd4;
      7'h4F:   misc_idx = 3'd5;
      default: misc_hit = 1'b0;
    endcase
    rdata = 16'h0000;
    if (cnt_hit)       rdata = cnt_sel2 ? reg2[cnt_idx] : reg1[cnt_idx];
    else if (div_hit)  rdata = divclk_reg;
    else if (misc_hit) rdata = misc_reg[misc_idx];
  end

  // NOTE: the register file is reset because the decoded outputs must read 0
  // straight out of reset; this is a small flop array, not a RAM.
  always_ff @(posedge DCLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < N_CNT; i++) begin
        reg1[i] <= '0;
        reg2[i] <= '0;
      end
      for (int i = 0; i < N_MISC; i++) misc_reg[i] <= '0;
      divclk_reg <= '0;
      cnt_cfg    <= '0;
      div_cfg    <= 1'b0;
      DO         <= '0;
      DRDY       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so the read below sees the register
      // contents from before any write at the same edge.
      DRDY <= access;
      if (access && !DWE) DO <= rdata;
      if (wr_en) begin
        if (cnt_hit) begin
          if (cnt_sel2) reg2[cnt_idx] <= DI;
          else          reg1[cnt_idx] <= DI;
          cnt_cfg[cnt_idx] <= 1'b1;
        end else if (div_hit) begin
          divclk_reg <= DI;
          div_cfg    <= 1'b1;
        end else if (misc_hit) begin
          misc_reg[misc_idx] <= DI;
        end
      end
    end
  end

  // Decode
  dec_t dec [N_CNT];

  always_comb begin
    for (int i = 0; i < N_CNT; i++) begin
      dec[i] = decode(cnt_cfg[i] && !PWRDWN,
                      reg1[i][15:13], reg1[i][11:6], reg1[i][5:0],
                      reg2[i][7], reg2[i][6], reg2[i][5:0]);
    end
  end

  assign CLKOUT5_DIVIDE          = dec[0].divide;
  assign CLKOUT5_DUTY_CYCLE_1000 = dec[0].duty;
  assign CLKOUT5_PHASE           = dec[0].phase;
  assign CLKOUT0_DIVIDE          = dec[1].divide;
  assign CLKOUT0_DUTY_CYCLE_1000 = dec[1].duty;
  assign CLKOUT0_PHASE           = dec[1].phase;
  assign CLKOUT1_DIVIDE          = dec[2].divide;
  assign CLKOUT1_DUTY_CYCLE_1000 = dec[2].duty;
  assign CLKOUT1_PHASE           = dec[2].phase;
  assign CLKOUT2_DIVIDE          = dec[3].divide;
  assign CLKOUT2_DUTY_CYCLE_1000 = dec[3].duty;
  assign CLKOUT2_PHASE           = dec[3].phase;
  assign CLKOUT3_DIVIDE          = dec[4].divide;
  assign CLKOUT3_DUTY_CYCLE_1000 = dec[4].duty;
  assign CLKOUT3_PHASE           = dec[4].phase;
  assign CLKOUT4_DIVIDE          = dec[5].divide;
  assign CLKOUT4_DUTY_CYCLE_1000 = dec[5].duty;
  assign CLKOUT4_PHASE           = dec[5].phase;
  assign CLKOUT6_DIVIDE          = dec[6].divide;
  assign CLKOUT6_DUTY_CYCLE_1000 = dec[6].duty;
  assign CLKOUT6_PHASE           = dec[6].phase;

  // Feedback divide is the multiplier; decode already yields 0 when disabled.
  assign CLKFBOUT_MULT_F_1000    = dec[7].divide * 32'd1000;
  assign CLKFBOUT_PHASE          = dec[7].phase;

  assign DIVCLK_DIVIDE = (div_cfg && !PWRDWN)
                       ? divide_of(divclk_reg[12], divclk_reg[11:6], divclk_reg[5:0])
                       : 32'd0;

endmodule

// File: tb/tb_pll_drp_config.sv
// ---------------------------------------------------------------------------
// tb_pll_drp_config
//
// Directed bench for pll_drp_config. Inputs change on the falling edge of
// DCLK, so every output is sampled half a cycle away from the active edge.
// Expected values are hand-computed from the register field definitions.
// ---------------------------------------------------------------------------
module tb_pll_drp_config;

  logic        dclk;
  logic        rst_n;
  logic        pwrdwn;
  logic [6:0]  daddr;
  logic        den;
  logic        dwe;
  logic [15:0] din;
  logic [15:0] dout;
  logic        drdy;
  logic [31:0] clkout0_divide, clkout0_duty, clkout0_phase;
  logic [31:0] clkout1_divide, clkout1_duty, clkout1_phase;
  logic [31:0] clkout2_divide, clkout2_duty, clkout2_phase;
  logic [31:0] clkout3_divide, clkout3_duty, clkout3_phase;
  logic [31:0] clkout4_divide, clkout4_duty, clkout4_phase;
  logic [31:0] clkout5_divide, clkout5_duty, clkout5_phase;
  logic [31:0] clkout6_divide, clkout6_duty, clkout6_phase;
  logic [31:0] clkfbout_mult, clkfbout_phase, divclk_divide;

  int n_vec;
  int n_miscompare;

  pll_drp_config dut (
    .DCLK                    (dclk),
    .RST                     (rst_n),
    .PWRDWN                  (pwrdwn),
    .DADDR                   (daddr),
    .DEN                     (den),
    .DWE                     (dwe),
    .DI                      (din),
    .DO                      (dout),
    .DRDY                    (drdy),
    .CLKOUT0_DIVIDE          (clkout0_divide),
    .CLKOUT0_DUTY_CYCLE_1000 (clkout0_duty),
    .CLKOUT0_PHASE           (clkout0_phase),
    .CLKOUT1_DIVIDE          (clkout1_divide),
    .CLKOUT1_DUTY_CYCLE_1000 (clkout1_duty),
    .CLKOUT1_PHASE           (clkout1_phase),
    .CLKOUT2_DIVIDE          (clkout2_divide),
    .CLKOUT2_DUTY_CYCLE_1000 (clkout2_duty),
    .CLKOUT2_PHASE           (clkout2_phase),
    .CLKOUT3_DIVIDE          (clkout3_divide),
    .CLKOUT3_DUTY_CYCLE_1000 (clkout3_duty),
    .CLKOUT3_PHASE           (clkout3_phase),
    .CLKOUT4_DIVIDE          (clkout4_divide),
    .CLKOUT4_DUTY_CYCLE_1000 (clkout4_duty),
    .CLKOUT4_PHASE           (clkout4_phase),
    .CLKOUT5_DIVIDE          (clkout5_divide),
    .CLKOUT5_DUTY_CYCLE_1000 (clkout5_duty),
    .CLKOUT5_PHASE           (clkout5_phase),
    .CLKOUT6_DIVIDE          (clkout6_divide),
    .CLKOUT6_DUTY_CYCLE_1000 (clkout6_duty),
    .CLKOUT6_PHASE           (clkout6_phase),
    .CLKFBOUT_MULT_F_1000    (clkfbout_mult),
    .CLKFBOUT_PHASE          (clkfbout_phase),
    .DIVCLK_DIVIDE           (divclk_divide)
  );

  initial dclk = 1'b0;
  always #5 dclk = ~dclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscompare++;
      $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", tag, obs, obs, exp, exp);
    end
  endtask

  // Called just after a falling edge: presents one DEN cycle, returns just
  // after the next falling edge, i.e. in the cycle where DRDY should be high.
  task automatic access(input logic [6:0] a, input logic we, input logic [15:0] d);
    daddr = a;
    den   = 1'b1;
    dwe   = we;
    din   = d;
    @(negedge dclk);
    den   = 1'b0;
    dwe   = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [6:0] a, input logic [15:0] d);
    access(a, 1'b1, d);
    check({tag, "_drdy"}, {31'd0, drdy}, 32'd1);
  endtask

  task automatic rd(input string tag, input logic [6:0] a, input logic [15:0] exp);
    access(a, 1'b0, 16'h0000);
    check({tag, "_drdy"}, {31'd0, drdy}, 32'd1);
    check({tag, "_do"}, {16'd0, dout}, {16'd0, exp});
  endtask

  task automatic idle_drdy_low(input string tag);
    @(negedge dclk);
    check(tag, {31'd0, drdy}, 32'd0);
  endtask

  initial begin
    n_vec        = 0;
    n_miscompare = 0;
    rst_n  = 1'b0;
    pwrdwn = 1'b0;
    daddr  = '0;
    den    = 1'b0;
    dwe    = 1'b0;
    din    = '0;

    // Reset state
    @(negedge dclk);
    @(negedge dclk);
    check("rst_drdy", {31'd0, drdy}, 32'd0);
    check("rst_do", {16'd0, dout}, 32'd0);
    check("rst_c0_div", clkout0_divide, 32'd0);
    check("rst_fb_mult", clkfbout_mult, 32'd0);
    check("rst_divclk", divclk_divide, 32'd0);
    rst_n = 1'b1;

    // First access right after release; DRDY lasts exactly one cycle
    rd("rd08_empty", 7'h08, 16'h0000);
    check("c0_div_unconf", clkout0_divide, 32'd0);
    idle_drdy_low("drdy_one_cycle");

    // CLKOUT0 HIGH=1 LOW=1
    wr("wr08", 7'h08, 16'h0041);
    check("wr_keeps_do", {16'd0, dout}, 32'd0);
    check("c0_div_2", clkout0_divide, 32'd2);
    check("c0_duty_2", clkout0_duty, 32'd500);
    check("c0_phase_2", clkout0_phase, 32'd0);
    rd("rd08", 7'h08, 16'h0041);

    // CLKOUT5: MUX=3 HIGH=2 LOW=2, then DELAY=1
    wr("wr06", 7'h06, 16'h6082);
    check("c5_div_a", clkout5_divide, 32'd4);
    check("c5_phase_a", clkout5_phase, 32'd33);      // 3*45/4
    wr("wr07", 7'h07, 16'h0001);
    check("c5_div", clkout5_divide, 32'd4);
    check("c5_duty", clkout5_duty, 32'd500);
    check("c5_phase", clkout5_phase, 32'd123);       // 11*45/4

    // Feedback HIGH=5 LOW=5, DIVCLK NO_COUNT
    wr("wr14", 7'h14, 16'h0145);
    check("fb_mult", clkfbout_mult, 32'd10000);
    check("fb_phase", clkfbout_phase, 32'd0);
    check("divclk_unconf", divclk_divide, 32'd0);
    wr("wr16", 7'h16, 16'h1000);
    check("divclk_nc", divclk_divide, 32'd1);

    // CLKOUT0 HIGH=1 LOW=2, then EDGE
    wr("wr08b", 7'h08, 16'h0042);
    check("c0_div_3", clkout0_divide, 32'd3);
    check("c0_duty_noedge", clkout0_duty, 32'd333);  // 2*500/3
    wr("wr09", 7'h09, 16'h0080);
    check("c0_duty_edge", clkout0_duty, 32'd500);    // 3*500/3

    // HIGH=LOW=0 means 64 each; a zero write still configures
    wr("wr0a", 7'h0A, 16'h0000);
    check("c1_div_128", clkout1_divide, 32'd128);
    check("c1_duty_128", clkout1_duty, 32'd500);
    // Reg2-only write with NO_COUNT configures the counter
    wr("wr0d", 7'h0D, 16'h0040);
    check("c2_div_nc", clkout2_divide, 32'd1);
    check("c2_duty_nc", clkout2_duty, 32'd500);
    // Phase is not reduced modulo 360: NO_COUNT, DELAY=63 -> 504*45
    wr("wr0f", 7'h0F, 16'h007F);
    check("c3_phase_big", clkout3_phase, 32'd22680);
    check("c4_div_unconf", clkout4_divide, 32'd0);
    check("c6_div_unconf", clkout6_divide, 32'd0);

    // Store-only registers and unmapped addresses
    wr("wr4f", 7'h4F, 16'hBEEF);
    rd("rd17", 7'h17, 16'h0000);
    rd("rd4f", 7'h4F, 16'hBEEF);
    wr("wr7f", 7'h7F, 16'hFFFF);
    check("wr7f_keeps_do", {16'd0, dout}, 32'h0000BEEF);
    rd("rd7f", 7'h7F, 16'h0000);

    // Back-to-back reads
    daddr = 7'h08; den = 1'b1; dwe = 1'b0;
    @(negedge dclk);
    daddr = 7'h4F;
    check("b2b_drdy0", {31'd0, drdy}, 32'd1);
    check("b2b_do0", {16'd0, dout}, 32'h00000042);
    @(negedge dclk);
    den = 1'b0;
    check("b2b_drdy1", {31'd0, drdy}, 32'd1);
    check("b2b_do1", {16'd0, dout}, 32'h0000BEEF);
    idle_drdy_low("b2b_end");

    // Power-down: outputs forced to 0, accesses ignored, state kept
    pwrdwn = 1'b1;
    #1;
    check("pd_c0_div", clkout0_divide, 32'd0);
    check("pd_c5_phase", clkout5_phase, 32'd0);
    check("pd_fb_mult", clkfbout_mult, 32'd0);
    check("pd_divclk", divclk_divide, 32'd0);
    @(negedge dclk);
    access(7'h08, 1'b1, 16'h0145);
    check("pd_wr_drdy", {31'd0, drdy}, 32'd0);
    access(7'h09, 1'b0, 16'h0000);
    check("pd_rd_drdy", {31'd0, drdy}, 32'd0);
    check("pd_rd_do", {16'd0, dout}, 32'h0000BEEF);
    pwrdwn = 1'b0;
    #1;
    check("pd_kept_c0_div", clkout0_divide, 32'd3);
    @(negedge dclk);
    rd("pd_kept_rd08", 7'h08, 16'h0042);

    // Reset in the middle of an access
    daddr = 7'h08; den = 1'b1; dwe = 1'b1; din = 16'h0145;
    @(posedge dclk);
    #2;
    rst_n = 1'b0;
    den   = 1'b0;
    dwe   = 1'b0;
    #1;
    check("mid_rst_drdy", {31'd0, drdy}, 32'd0);
    check("mid_rst_do", {16'd0, dout}, 32'd0);
    check("mid_rst_c0_div", clkout0_divide, 32'd0);
    check("mid_rst_c5_phase", clkout5_phase, 32'd0);
    check("mid_rst_fb_mult", clkfbout_mult, 32'd0);
    check("mid_rst_divclk", divclk_divide, 32'd0);
    @(negedge dclk);
    rst_n = 1'b1;
    idle_drdy_low("post_rst_no_drdy");
    rd("post_rst_rd08", 7'h08, 16'h0000);
    rd("post_rst_rd4f", 7'h4F, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
    $finish;
  end

endmodule

// File: doc/pll_drp_config.md
# pll_drp_config

Dynamic-reconfiguration (DRP) register file and decoder for the PLL simulation model. It accepts 7-series-style DRP reads and writes on one clock and stores the PLL counter registers. It decodes them into the integer divide, duty-cycle (×1000) and phase values that the PLL core uses to override its static parameters. Every decoded output is 0 while its counter is unconfigured, and the PLL core ignores 0 values.

## Interface
- Parameters: none.
- DCLK  in  1  sole clock; all state changes on its rising edge.
- RST  in  1  asynchronous, active-low reset.
- PWRDWN  in  1  power-down; while 1, DRP accesses are ignored and all decoded outputs read 0. Stored registers are kept.
- DADDR  in  7  register address.
- DEN  in  1  access strobe, one cycle per access.
- DWE  in  1  write enable, qualified by DEN.
- DI  in  16  write data.
- DO  out  16  read data, valid while DRDY=1.
- DRDY  out  1  one-cycle access-complete pulse.
- CLKOUTn_DIVIDE, CLKOUTn_DUTY_CYCLE_1000, CLKOUTn_PHASE, for n=0..6  out  32 each  decoded output-counter values.
- CLKFBOUT_MULT_F_1000  out  32  feedback multiplier ×1000.
- CLKFBOUT_PHASE  out  32  feedback phase in degrees.
- DIVCLK_DIVIDE  out  32  input divider.

## Operation
- Register map:
  - Counter pairs (Reg1, Reg2): CLKOUT5 0x06/0x07; CLKOUT0 0x08/0x09; CLKOUT1 0x0A/0x0B; CLKOUT2 0x0C/0x0D; CLKOUT3 0x0E/0x0F; CLKOUT4 0x10/0x11; CLKOUT6 0x12/0x13; CLKFBOUT 0x14/0x15.
  - DIVCLK at 0x16.
  - Store-only registers with readback and no decode: 0x18, 0x19, 0x1A, 0x28, 0x4E, 0x4F.
  - All 16 bits are stored as written.
- Reg1 fields: [15:13] PHASE_MUX, [11:6] HIGH, [5:0] LOW.
- Reg2 fields: [7] EDGE, [6] NO_COUNT, [5:0] DELAY.
- DIVCLK fields: [13] EDGE, [12] NO_COUNT, [11:6] HIGH, [5:0] LOW.
- Field rule: a HIGH or LOW field of 0 means 64.
- Configured flag: one per counter. It is set by a write to either register of that counter and cleared only by reset. Unconfigured counters output 0 on all of their decoded ports.
- Decode for a configured counter:
  - divide D = NO_COUNT ? 1 : HIGH+LOW.
  - duty_1000 = NO_COUNT ? 500 : ((2·HIGH+EDGE)·500)/D, truncated.
  - phase = ((DELAY·8+PHASE_MUX)·45)/D, truncated, unsigned, not reduced modulo 360.
- Feedback outputs: CLKFBOUT_MULT_F_1000 = D_fb·1000; CLKFBOUT_PHASE uses the phase formula on the 0x14/0x15 pair.
- DIVCLK_DIVIDE uses the divide formula on 0x16.
- Decoded outputs are combinational from the stored registers, flags and PWRDWN.
- Reads:
  - A read of a mapped address returns the stored value.
  - A read of an unmapped address returns 0x0000.
- Writes:
  - A write to a mapped address updates the register.
  - A write to an unmapped address changes nothing, but still produces DRDY.

## Timing
- Access: DEN=1 sampled at edge n.
  - A write updates the register at edge n, and decoded outputs change right after edge n.
  - DRDY=1 for exactly the cycle after edge n.
  - For a read, DO is loaded at edge n with the value before any same-edge write.
- Back-to-back accesses (DEN on consecutive cycles) are all accepted, giving consecutive DRDY pulses.
- DO holds its last read value until the next read. A write does not change DO.
- PWRDWN=1 at an edge with DEN=1: no register update and no DRDY.
- Reset (RST=0), asynchronously:
  - all registers and configured flags cleared;
  - DO=0x0000, DRDY=0, all decoded outputs 0.
- Reset in the middle of an access aborts it: no DRDY is issued after reset releases.
- Release from reset is synchronous to DCLK. The first DEN is accepted at the first edge with RST=1.

## Test plan
- Reset, then read 0x08: DRDY pulses one cycle after DEN, DO=0x0000, CLKOUT0_DIVIDE=0.
- Write 0x08=0x0041 (HIGH=1, LOW=1): CLKOUT0_DIVIDE=2, DUTY_1000=500, PHASE=0. Reading 0x08 returns 0x0041.
- Write 0x06=0x6082 (MUX=3, HIGH=2, LOW=2), then 0x07=0x0001 (DELAY=1): CLKOUT5_DIVIDE=4, DUTY=500, PHASE=(8+3)·45/4=123.
- Write 0x14=0x0145 (HIGH=5, LOW=5) and 0x16=0x1000 (NO_COUNT): CLKFBOUT_MULT_F_1000=10000, DIVCLK_DIVIDE=1.
- Write 0x09=0x0080 (EDGE) after 0x08=0x0042 (HIGH=1, LOW=2): DIVIDE=3, DUTY=(2+1)·500/3=500.
- Access to unmapped 0x7F with DWE=1 then DWE=0: both give DRDY, the read returns 0. With PWRDWN=1, DEN gives no DRDY and all decoded outputs are 0. Asserting RST mid-run clears everything.
